// File: rtl/fp_special_result_gen.sv
// Special-case result override for the FMA output: canonical NaN, +/-Inf or signed zero,
// chosen from issue-time operand flags carried alongside the core pipeline.
module fp_special_result_gen #(
  parameter int EXP_WIDTH  = 8,
  parameter int CSIG_WIDTH = 23,
  parameter int CWIDTH     = 1 + EXP_WIDTH + CSIG_WIDTH,
  parameter int LATENCY    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_nan,
  input  logic                 s_pinf,
  input  logic                 s_ninf,
  input  logic                 s_inf_x_zero,
  input  logic                 s_prod_zero,
  input  logic                 s_prod_sign,
  input  logic                 s_c_zero,
  input  logic                 s_c_sign,
  output logic                 pipe_en,
  input  logic                 dp_valid,
  input  logic [CWIDTH-1:0]    dp_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CWIDTH-1:0]    m_result,
  output logic                 m_special,
  output logic [CNT_WIDTH-1:0] nan_count,
  output logic                 align_err,
  input  logic                 clr
);

  localparam int NST = LATENCY - 1;

  localparam logic [CWIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(CSIG_WIDTH-1){1'b0}}};
  localparam logic [CWIDTH-1:0] PINF = {1'b0, {EXP_WIDTH{1'b1}}, {CSIG_WIDTH{1'b0}}};
  localparam logic [CWIDTH-1:0] NINF = {1'b1, {EXP_WIDTH{1'b1}}, {CSIG_WIDTH{1'b0}}};

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
    logic inf_x_zero;
    logic prod_zero;
    logic prod_sign;
    logic c_zero;
    logic c_sign;
  } flags_t;

  logic [NST:1]          vld_q, vld_d;
  flags_t                flg_q [1:NST];
  flags_t                flg_d [1:NST];
  logic                  m_valid_q, m_valid_d;
  logic [CWIDTH-1:0]     m_result_q, m_result_d;
  logic                  m_special_q, m_special_d;
  logic                  m_isnan_q, m_isnan_d;
  logic [CNT_WIDTH-1:0]  nan_count_q, nan_count_d;
  logic                  align_err_q, align_err_d;

  flags_t                f;
  logic                  is_nan;
  logic [CWIDTH-1:0]     res_sel;
  logic                  spec_sel;

  assign pipe_en   = ~m_valid_q | m_ready;
  assign s_ready   = pipe_en;
  assign m_valid   = m_valid_q;
  assign m_result  = m_result_q;
  assign m_special = m_special_q;
  assign nan_count = nan_count_q;
  assign align_err = align_err_q;

  always_comb begin
    vld_d = vld_q;
    flg_d = flg_q;
    if (pipe_en) begin
      vld_d[1] = s_valid;
      flg_d[1] = {s_nan, s_pinf, s_ninf, s_inf_x_zero,
                  s_prod_zero, s_prod_sign, s_c_zero, s_c_sign};
      for (int i = 2; i <= NST; i++) begin
        vld_d[i] = vld_q[i-1];
        flg_d[i] = flg_q[i-1];
      end
    end
  end

  assign f      = flg_q[NST];
  assign is_nan = f.nan | f.inf_x_zero | (f.pinf & f.ninf);

  always_comb begin
    res_sel  = dp_result;
    spec_sel = 1'b1;
    if (is_nan)                     res_sel = QNAN;
    else if (f.pinf)                res_sel = PINF;
    else if (f.ninf)                res_sel = NINF;
    // exact-zero sum under round-to-nearest is -0 only when both addends are -0
    else if (f.prod_zero & f.c_zero) res_sel = {f.prod_sign & f.c_sign, {(CWIDTH-1){1'b0}}};
    else                            spec_sel = 1'b0;
  end

  always_comb begin
    m_valid_d   = m_valid_q;
    m_result_d  = m_result_q;
    m_special_d = m_special_q;
    m_isnan_d   = m_isnan_q;
    if (pipe_en) begin
      m_valid_d = vld_q[NST];
      if (vld_q[NST]) begin
        m_result_d  = res_sel;
        m_special_d = spec_sel;
        m_isnan_d   = is_nan;
      end
    end
  end

  always_comb begin
    align_err_d = align_err_q | (pipe_en & vld_q[NST] & ~dp_valid);
    nan_count_d = nan_count_q;
    if (m_valid_q & m_ready & m_isnan_q & (nan_count_q != {CNT_WIDTH{1'b1}}))
      nan_count_d = nan_count_q + 1'b1;
    if (clr) begin
      align_err_d = 1'b0;
      nan_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
      m_special_q <= 1'b0;
      m_isnan_q   <= 1'b0;
      nan_count_q <= '0;
      align_err_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      m_valid_q   <= m_valid_d;
      m_result_q  <= m_result_d;
      m_special_q <= m_special_d;
      m_isnan_q   <= m_isnan_d;
      nan_count_q <= nan_count_d;
      align_err_q <= align_err_d;
    end
  end

  // flag payload is qualified by vld_q, so it carries no reset
  always_ff @(posedge clk) begin
    flg_q <= flg_d;
  end

endmodule
